// File: rtl/mem_burst_ctrl.sv
// Burst master for a single-port synchronous RAM: drives the shared address/RW/CS bus
// and the tristate data bus for one read or write burst at a time.
module mem_burst_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [LW-1:0]    req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic [AW-1:0]    a,
  output logic             RW,
  output logic             CS,
  inout  wire  [WIDTH-1:0] d
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD_ADDR = 2'd2;
  localparam logic [1:0] RD_DATA = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] cnt;
  logic [AW-1:0] addr;
  logic          last_beat;

  assign busy      = (state != IDLE);
  assign req_ready = ~busy;
  assign wr_ready  = (state == WR);
  assign RW        = (state != WR);
  assign a         = addr;
  assign last_beat = (cnt == '0);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    CS = 1'b0;
    case (state)
      WR:      CS = wr_valid;
      RD_ADDR: CS = 1'b1;
      RD_DATA: CS = 1'b1;
      default: CS = 1'b0;
    endcase
  end

  // The bus is released as soon as reset forces IDLE, since CS is decoded from state.
  assign d = (CS && !RW) ? wr_data : {WIDTH{1'bz}};

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      cnt      <= '0;
      addr     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr  <= req_addr;
            cnt   <= req_len;
            state <= req_we ? WR : RD_ADDR;
          end
        end
        WR: begin
          if (wr_valid) begin
            addr <= addr + 1'b1;
            if (last_beat) state <= IDLE;
            else           cnt   <= cnt - 1'b1;
          end
        end
        RD_ADDR: begin
          addr  <= addr + 1'b1;
          state <= RD_DATA;
        end
        RD_DATA: begin
          // The word on d belongs to the address presented one cycle earlier.
          rd_data  <= d;
          rd_valid <= 1'b1;
          addr     <= addr + 1'b1;
          if (last_beat) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Bus master that drives the single-port synchronous RAM's shared address/RW/CS/tristate-data bus on behalf of a requester (CPU/DMA). It accepts one burst request at a time of 1..2^LW beats, read or write, at incrementing wrapping addresses. Read beats are pipelined so the RAM issues one address per cycle. The block is the only master on the RAM bus and sits directly upstream of the RAM.

Parameters:
WIDTH, 16, data word width; equals the RAM data width.
AW, 8, address width; equals the RAM address width.
LW, 4, burst length field width; beats = req_len + 1.

Ports:
clk  input  1  system clock, rising edge.
res  input  1  asynchronous active-low reset.
req_valid  input  1  requester presents a burst command.
req_ready  output  1  controller can accept a command.
req_we  input  1  1 = write burst, 0 = read burst.
req_addr  input  AW  first beat address.
req_len  input  LW  beats minus one.
wr_valid  input  1  wr_data holds a valid write beat.
wr_ready  output  1  controller consumes the write beat this cycle.
wr_data  input  WIDTH  write beat data.
rd_valid  output  1  rd_data holds a read beat (1-cycle pulse per beat).
rd_data  output  WIDTH  read beat data.
busy  output  1  burst in progress (state != IDLE).
a  output  AW  RAM address.
RW  output  1  RAM direction: 1 = read, 0 = write.
CS  output  1  RAM chip select, active high.
d  inout  WIDTH  RAM data bus.

Behaviour:
- Reset (async, res=0): state IDLE, CS=0, RW=1, a=0, rd_valid=0, rd_data=0, busy=0, beat counter=0. d is released to Z immediately, with no clock required.
- d is driven with wr_data only when CS=1 and RW=0. Otherwise it is Z. The controller never drives d while RW=1.
- States: IDLE, WR, RD_ADDR, RD_DATA.
- IDLE: req_ready=1, CS=0, RW=1, a holds its last value. On req_valid at a clock edge, latch addr/len/we and go to WR (we=1) or RD_ADDR (we=0). A command presented while busy is not accepted (req_ready=0) and must be held by the requester.
- WR: wr_ready=1, RW=0, CS=wr_valid, a=current address. A beat completes at the edge where wr_valid=1: the RAM writes, the address increments mod 2^AW, and the remaining count decrements. wr_valid=0 stalls with CS=0, so there is no RAM write. After the last beat, go to IDLE.
- RD_ADDR: one cycle with CS=1, RW=1, a=first address. The RAM registers the word at the edge. The address increments and the state goes to RD_DATA.
- RD_DATA: CS=1, RW=1. The RAM drives the previous word onto d while a presents the next address.
  - Each edge: rd_data<=d, rd_valid<=1, address++, count--.
  - On the last beat, go to IDLE. The extra RAM read issued in that cycle is harmless and its data is discarded.
  - rd_valid is 0 in every other cycle.
- Read timing: the first rd_valid is high in the 3rd cycle after the acceptance edge. An N-beat read occupies N+1 busy cycles and delivers data on N consecutive cycles. Reads have no back-pressure.
- Address wrap: AW-bit increment; 2^AW-1 is followed by 0.
- req_len=2^LW-1 produces 2^LW beats. The counter must not underflow.
- Reset mid-burst: the burst is aborted, remaining beats are discarded, and RAM words not yet written keep their old contents.
- busy=1 in every state except IDLE. req_ready = ~busy.

Test Plan:
- Write 1 beat (addr 0x10, data 0xBEEF), then read 1 beat at 0x10 -> no write cycle has CS=1 with RW=1. rd_valid pulses once with rd_data=0xBEEF, 2 cycles after read acceptance.
- Write burst addr 0xFE, len 3, data 0x1111..0x4444 -> RAM[0xFE]=0x1111, [0xFF]=0x2222, [0x00]=0x3333, [0x01]=0x4444. A 4-beat read from 0xFE returns the same values on 4 consecutive rd_valid cycles. busy is high 5 cycles.
- Write burst with wr_valid low for 2 cycles mid-burst -> CS=0 during the gap, no extra writes, and the final contents match the supplied beats in order.
- Read of never-written addr 0x80 after reset -> rd_data=0x0000.
- Assert res low during beat 2 of a 4-beat write -> CS=0 and d=Z immediately, busy=0, RAM[addr+2] and RAM[addr+3] unchanged. A new request is accepted after res rises.
- Hold req_valid during a burst -> req_ready=0 and the command is not accepted. It is accepted on the first edge after IDLE is re-entered.
